// File: rtl/mul_pkg.sv
// Shared definitions for the multiply functional-unit controller:
// datapath widths and the per-stage {valid, tag, product} record.
package mul_pkg;

  localparam int XLEN      = 32;
  localparam int PROD_W    = 64;
  localparam int TAG_W_DEF = 4;

  typedef logic [XLEN-1:0]   xlen_t;
  typedef logic [PROD_W-1:0] prod_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W_DEF-1:0] tag;
    prod_t                product;
  } stage_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with enable and a registered last-winner pointer.
// Search starts one past the previous winner; pointer resets so requester 0 wins first.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;
  int            idx;

  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    if (en_i) begin
      for (int i = 1; i <= N; i++) begin
        idx = (int'(ptr_q) + i) % N;
        if (!found && req_i[idx]) begin
          found      = 1'b1;
          gnt_o[idx] = 1'b1;
          ptr_d      = PW'(idx);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= PW'(N - 1);
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/wallace_mul32.sv
// Combinational unsigned 32x32->64 multiplier datapath (behavioural form of the tree).
module wallace_mul32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] p_o
);

  assign p_o = {32'd0, a_i} * {32'd0, b_i};

endmodule

// File: rtl/mul_unit_ctrl.sv
// Issue/completion controller for the shared multiplier: RR issue, fixed-latency
// pipeline carrying tag/valid, result FIFO toward the CDB, credit-based back-pressure.
module mul_unit_ctrl
  import mul_pkg::*;
#(
  parameter int NUM_RS    = 3,
  parameter int TAG_W     = TAG_W_DEF,
  parameter int LAT       = 2,
  parameter int BUF_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic [NUM_RS-1:0]       rs_req,
  input  logic [NUM_RS*32-1:0]    rs_src1,
  input  logic [NUM_RS*32-1:0]    rs_src2,
  input  logic [NUM_RS*TAG_W-1:0] rs_tag,
  output logic [NUM_RS-1:0]       rs_gnt,
  output logic                    cdb_valid,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [PROD_W-1:0]       cdb_data,
  input  logic                    cdb_ack,
  output logic                    full
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  logic          kill, issue_en, issue, push, pop;
  logic [CW-1:0] occ_q, occ_d;

  assign kill     = !rst_n || flush;
  assign issue_en = rst_n && !flush && (occ_q < CW'(BUF_DEPTH));
  assign issue    = |rs_gnt;

  rr_arbiter #(.N(NUM_RS)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (issue_en),
    .req_i (rs_req),
    .gnt_o (rs_gnt)
  );

  xlen_t            src1_sel, src2_sel;
  logic [TAG_W-1:0] tag_sel;

  always_comb begin
    src1_sel = '0;
    src2_sel = '0;
    tag_sel  = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (rs_gnt[i]) begin
        src1_sel = rs_src1[32*i +: 32];
        src2_sel = rs_src2[32*i +: 32];
        tag_sel  = rs_tag[TAG_W*i +: TAG_W];
      end
    end
  end

  // ---- stage 1: operand capture ----
  logic             vld_p1_q;
  xlen_t            src1_p1_q, src2_p1_q;
  logic [TAG_W-1:0] tag_p1_q;
  prod_t            prod_p1;

  always_ff @(posedge clk) begin
    if (kill) vld_p1_q <= 1'b0;
    else      vld_p1_q <= issue;
    src1_p1_q <= src1_sel;
    src2_p1_q <= src2_sel;
    tag_p1_q  <= tag_sel;
  end

  wallace_mul32 u_mul (
    .a_i (src1_p1_q),
    .b_i (src2_p1_q),
    .p_o (prod_p1)
  );

  // ---- stages 2..LAT: product/tag/valid forwarding ----
  stage_t pipe_p2_q [LAT-1];

  always_ff @(posedge clk) begin
    pipe_p2_q[0] <= '{valid: vld_p1_q, tag: TAG_W_DEF'(tag_p1_q), product: prod_p1};
    for (int s = 1; s < LAT - 1; s++) pipe_p2_q[s] <= pipe_p2_q[s-1];
    if (kill) begin
      for (int s = 0; s < LAT - 1; s++) pipe_p2_q[s].valid <= 1'b0;
    end
  end

  // ---- result FIFO toward the CDB ----
  logic [TAG_W-1:0] fifo_tag_q  [BUF_DEPTH];
  prod_t            fifo_data_q [BUF_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(BUF_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign push = pipe_p2_q[LAT-2].valid && !flush;
  assign pop  = cdb_valid && cdb_ack && !flush;

  always_ff @(posedge clk) begin
    if (kill) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_tag_q[wr_ptr_q]  <= TAG_W'(pipe_p2_q[LAT-2].tag);
      fifo_data_q[wr_ptr_q] <= pipe_p2_q[LAT-2].product;
    end
  end

  assign cdb_valid = (cnt_q != '0);
  assign cdb_tag   = cdb_valid ? fifo_tag_q[rd_ptr_q]  : '0;
  assign cdb_data  = cdb_valid ? fifo_data_q[rd_ptr_q] : '0;

  // Credits cover in-flight plus buffered ops; a same-cycle pop is not re-used for issue.
  always_comb begin
    occ_d = occ_q + CW'(issue) - CW'(pop);
    if (kill) occ_d = '0;
  end

  always_ff @(posedge clk) begin
    occ_q <= occ_d;
  end

  assign full = (occ_q == CW'(BUF_DEPTH));

endmodule

// File: tb/tb_mul_unit_ctrl.sv
// Randomised bench for mul_unit_ctrl with a queue-based reference model and CDB monitor.
module tb_mul_unit_ctrl;

  localparam int NUM_RS    = 3;
  localparam int TAG_W     = 4;
  localparam int LAT       = 2;
  localparam int BUF_DEPTH = 4;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    flush = 1'b0;
  logic [NUM_RS-1:0]       rs_req = '0;
  logic [NUM_RS*32-1:0]    rs_src1 = '0;
  logic [NUM_RS*32-1:0]    rs_src2 = '0;
  logic [NUM_RS*TAG_W-1:0] rs_tag = '0;
  logic [NUM_RS-1:0]       rs_gnt;
  logic                    cdb_valid;
  logic [TAG_W-1:0]        cdb_tag;
  logic [63:0]             cdb_data;
  logic                    cdb_ack = 1'b0;
  logic                    full;

  mul_unit_ctrl #(.NUM_RS(NUM_RS), .TAG_W(TAG_W), .LAT(LAT), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .rs_req    (rs_req),
    .rs_src1   (rs_src1),
    .rs_src2   (rs_src2),
    .rs_tag    (rs_tag),
    .rs_gnt    (rs_gnt),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_ack   (cdb_ack),
    .full      (full)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [63:0]      prod;
    int               due;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   m_occ = 0;
  int   m_ptr = NUM_RS - 1;
  bit   mon_en = 1'b0;
  bit   rand_data = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] rand_op();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return 32'hFFFF_FFFF;
    if (r == 1) return 32'd0;
    return $urandom;
  endfunction

  // One clock cycle: drive inputs, predict grant/full, record issued ops.
  task automatic step(input logic rn, input logic fl, input logic ack, input logic [NUM_RS-1:0] req);
    logic [NUM_RS-1:0] exp_g;
    int                g, idx;
    bit                pop_m;
    logic [31:0]       a, b;
    @(negedge clk);
    rst_n   = rn;
    flush   = fl;
    cdb_ack = ack;
    rs_req  = req;
    if (rand_data) begin
      for (int i = 0; i < NUM_RS; i++) begin
        rs_src1[32*i +: 32]       = rand_op();
        rs_src2[32*i +: 32]       = rand_op();
        rs_tag[TAG_W*i +: TAG_W]  = TAG_W'($urandom);
      end
    end
    #1;
    exp_g = '0;
    g     = -1;
    if (rn && !fl && m_occ < BUF_DEPTH) begin
      for (int k = 1; k <= NUM_RS; k++) begin
        idx = (m_ptr + k) % NUM_RS;
        if (g < 0 && req[idx]) g = idx;
      end
    end
    if (g >= 0) exp_g[g] = 1'b1;
    if (mon_en) begin
      chk("rs_gnt", 64'(rs_gnt), 64'(exp_g));
      chk("full", 64'(full), 64'(m_occ == BUF_DEPTH));
    end
    pop_m = rn && !fl && ack && exp_q.size() > 0 && exp_q[0].due <= cyc;
    if (g >= 0) begin
      a = rs_src1[32*g +: 32];
      b = rs_src2[32*g +: 32];
      exp_q.push_back('{tag: rs_tag[TAG_W*g +: TAG_W], prod: {32'd0, a} * {32'd0, b}, due: cyc + LAT + 1});
      m_ptr = g;
      m_occ++;
    end
    if (pop_m) m_occ--;
    #2;
    if (!rn || fl) begin
      exp_q.delete();
      m_occ = 0;
      if (!rn) m_ptr = NUM_RS - 1;
    end
  endtask

  // CDB monitor: every presented result must be the oldest due op.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        if (cdb_valid === 1'b1) begin
          if (exp_q.size() == 0 || exp_q[0].due > cyc) begin
            checks++;
            errors++;
            $display("FAIL cdb_unexpected cyc=%0d got tag=%h data=%h want none", cyc, cdb_tag, cdb_data);
          end else begin
            chk("cdb_tag", 64'(cdb_tag), 64'(exp_q[0].tag));
            chk("cdb_data", cdb_data, exp_q[0].prod);
            if (cdb_ack && rst_n && !flush) void'(exp_q.pop_front());
          end
        end else begin
          checks++;
          if (cdb_valid !== 1'b0 || (exp_q.size() > 0 && exp_q[0].due <= cyc)) begin
            errors++;
            $display("FAIL cdb_valid cyc=%0d got=%b want=1", cyc, cdb_valid);
          end
          chk("cdb_tag_idle", 64'(cdb_tag), 64'd0);
          chk("cdb_data_idle", cdb_data, 64'd0);
        end
      end
    end
  end

  // A push must never land in a full buffer.
  always @(negedge clk) begin
    if (mon_en && dut.push === 1'b1 && dut.cnt_q == 3'(BUF_DEPTH)) begin
      errors++;
      $display("FAIL fifo_overflow cyc=%0d got cnt=%0d want<%0d", cyc, dut.cnt_q, BUF_DEPTH);
    end
  end

  initial begin
    logic rn, fl, ack;
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    mon_en = 1'b1;
    step(1'b0, 1'b0, 1'b0, '0);

    // single op: 0xFFFFFFFF * 2, tag 5
    rand_data = 1'b0;
    rs_src1[31:0] = 32'hFFFF_FFFF;
    rs_src2[31:0] = 32'd2;
    rs_tag[TAG_W-1:0] = 4'd5;
    step(1'b1, 1'b0, 1'b1, 3'b001);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 3'b000);
    rand_data = 1'b1;

    // round-robin with continuous ack
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b1, 3'b111);
    for (int i = 0; i < 6; i++)  step(1'b1, 1'b0, 1'b1, 3'b000);

    // back-pressure, single ack, then drain
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 3'b001);
    step(1'b1, 1'b0, 1'b1, 3'b001);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 3'b001);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1, 3'b000);

    // issue/pop at steady state, then flush with ops in flight and buffered
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 3'b010);
    step(1'b1, 1'b1, 1'b1, 3'b010);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 3'b110);

    // mid-operation reset
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 3'b111);
    step(1'b0, 1'b0, 1'b1, 3'b111);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 3'b100);

    // randomised traffic
    for (int i = 0; i < 600; i++) begin
      rn  = ($urandom_range(0, 63) != 0);
      fl  = ($urandom_range(0, 19) == 0);
      ack = ($urandom_range(0, 3) != 0);
      step(rn, fl, ack, NUM_RS'($urandom));
    end

    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b1, 3'b000);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
